// File: rtl/mux8way_rr_arbiter.sv
// Eight-way valid/ready round-robin merge onto one registered output channel.
// Optional packet lock (in_last/out_last) enabled by MUX8WAY_RR_ARBITER_LOCK_EN.
module mux8way_rr_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [8*WIDTH-1:0] in_data,
    input  logic [7:0]         in_valid,
    output logic [7:0]         in_ready,
`ifdef MUX8WAY_RR_ARBITER_LOCK_EN
    input  logic [7:0]         in_last,
    output logic               out_last,
`endif
    output logic [WIDTH-1:0]   out_data,
    output logic [2:0]         out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [2:0]       ptr;
    logic             can_load;
    logic             grant_found;
    logic [2:0]       grant_idx;
    logic [2:0]       cand;
    logic             xfer;
    logic [WIDTH-1:0] win_data;

`ifdef MUX8WAY_RR_ARBITER_LOCK_EN
    localparam logic [0:0] ARB  = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    logic [0:0] state;
    logic [2:0] lock_ch;
`endif

    assign can_load = !out_valid || out_ready;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
`ifdef MUX8WAY_RR_ARBITER_LOCK_EN
        if (state == LOCK) begin
            // Locked: only the owning channel may win, even while it is idle.
            grant_found = in_valid[lock_ch];
            grant_idx   = lock_ch;
        end else begin
`endif
            for (int unsigned k = 0; k < 8; k++) begin
                cand = ptr + k[2:0];
                if (!grant_found && in_valid[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
`ifdef MUX8WAY_RR_ARBITER_LOCK_EN
        end
`endif
    end

    assign xfer     = grant_found && can_load && !reset;
    assign in_ready = xfer ? (8'(1) << grant_idx) : '0;
    assign win_data = in_data[grant_idx*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
`ifdef MUX8WAY_RR_ARBITER_LOCK_EN
            out_last  <= 1'b0;
            state     <= ARB;
            lock_ch   <= '0;
`endif
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= win_data;
            out_sel   <= grant_idx;
`ifdef MUX8WAY_RR_ARBITER_LOCK_EN
            out_last  <= in_last[grant_idx];
            if (state == ARB) begin
                ptr <= grant_idx + 3'd1;
                if (!in_last[grant_idx]) begin
                    state   <= LOCK;
                    lock_ch <= grant_idx;
                end
            end else if (in_last[grant_idx]) begin
                state <= ARB;
                ptr   <= grant_idx + 3'd1;
            end
`else
            ptr       <= grant_idx + 3'd1;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux8way_rr_arbiter.sv
// Directed self-checking bench for mux8way_rr_arbiter; lock test runs only
// when MUX8WAY_RR_ARBITER_LOCK_EN is defined.
module tb_mux8way_rr_arbiter;

    localparam int WIDTH = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic [8*WIDTH-1:0] in_data;
    logic [7:0]         in_valid;
    logic [7:0]         in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [2:0]         out_sel;
    logic               out_valid;
    logic               out_ready;
`ifdef MUX8WAY_RR_ARBITER_LOCK_EN
    logic [7:0]         in_last;
    logic               out_last;
`endif

    int errors = 0;
    int checks = 0;

    mux8way_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef MUX8WAY_RR_ARBITER_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 8'hFF;
        in_data   = '0;
        out_ready = 1'b1;
        step();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_data got=%h exp=0000", out_data); end
        checks++; if (out_sel !== 3'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", out_sel); end
        checks++; if (in_ready !== 8'h00) begin errors++; $display("FAIL reset_ready got=%h exp=00", in_ready); end
        in_valid = 8'h00;
        reset    = 1'b0;
        step();
    endtask

    task automatic test_single();
        in_data[2*WIDTH +: WIDTH] = 16'h1234;
        in_valid  = 8'h04;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 8'h04) begin errors++; $display("FAIL single_ready got=%h exp=04", in_ready); end
        step();
        in_valid = 8'h00;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 16'h1234) begin errors++; $display("FAIL single_data got=%h exp=1234", out_data); end
        checks++; if (out_sel !== 3'd2) begin errors++; $display("FAIL single_sel got=%0d exp=2", out_sel); end
        // ptr now 3: with everything requesting, channel 3 wins.
        in_valid = 8'hFF;
        #1;
        checks++; if (in_ready !== 8'h08) begin errors++; $display("FAIL single_ptr got=%h exp=08", in_ready); end
        in_valid = 8'h00;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", out_valid); end
        checks++; if (out_data !== 16'h1234) begin errors++; $display("FAIL single_hold got=%h exp=1234", out_data); end
    endtask

    task automatic test_fairness();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) in_data[i*WIDTH +: WIDTH] = 16'hA000 + 16'(i);
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_sel !== 3'(k % 8) || out_data !== 16'hA000 + 16'(k % 8)) begin
                errors++;
                $display("FAIL fair_%0d got v=%b sel=%0d data=%h exp v=1 sel=%0d data=%h",
                         k, out_valid, out_sel, out_data, k % 8, 16'hA000 + 16'(k % 8));
            end
        end
        in_valid = 8'h00;
    endtask

    task automatic test_wrap();
        logic [2:0] exp_sel [3];
        exp_sel[0] = 3'd0; exp_sel[1] = 3'd5; exp_sel[2] = 3'd0;
        in_valid = 8'h40;
        step();
        checks++; if (out_sel !== 3'd6) begin errors++; $display("FAIL wrap_six got=%0d exp=6", out_sel); end
        in_valid = 8'h21;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (out_sel !== exp_sel[k] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL wrap_%0d got sel=%0d v=%b exp sel=%0d v=1", k, out_sel, out_valid, exp_sel[k]);
            end
        end
        in_valid = 8'h00;
        step();
    endtask

    task automatic test_backpressure();
        // ptr is 1 after the wrap sequence.
        in_data[1*WIDTH +: WIDTH] = 16'hBEEF;
        in_data[3*WIDTH +: WIDTH] = 16'h3333;
        out_ready = 1'b0;
        in_valid  = 8'h02;
        step();
        checks++; if (out_data !== 16'hBEEF || out_sel !== 3'd1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_load got d=%h s=%0d v=%b exp d=beef s=1 v=1", out_data, out_sel, out_valid);
        end
        in_valid = 8'h08;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (in_ready !== 8'h00 || out_data !== 16'hBEEF || out_sel !== 3'd1 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_stall_%0d got r=%h d=%h s=%0d v=%b exp r=00 d=beef s=1 v=1",
                         k, in_ready, out_data, out_sel, out_valid);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 8'h08) begin errors++; $display("FAIL bp_release_ready got=%h exp=08", in_ready); end
        step();
        in_valid = 8'h00;
        checks++; if (out_data !== 16'h3333 || out_sel !== 3'd3 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_reload got d=%h s=%0d v=%b exp d=3333 s=3 v=1", out_data, out_sel, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || out_data !== 16'h0 || out_sel !== 3'd0) begin
            errors++; $display("FAIL midreset got v=%b d=%h s=%0d exp v=0 d=0000 s=0", out_valid, out_data, out_sel);
        end
        reset    = 1'b0;
        in_valid = 8'h30;
        step();
        in_valid = 8'h00;
        checks++; if (out_sel !== 3'd4 || out_valid !== 1'b1) begin
            errors++; $display("FAIL midreset_grant got s=%0d v=%b exp s=4 v=1", out_sel, out_valid);
        end
        step();
    endtask

`ifdef MUX8WAY_RR_ARBITER_LOCK_EN
    task automatic test_lock();
        reset = 1'b1;
        step();
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL lock_reset_last got=%b exp=0", out_last); end
        reset     = 1'b0;
        out_ready = 1'b1;
        in_last   = 8'hFF;
        in_data[0*WIDTH +: WIDTH] = 16'h0AAA;
        in_valid  = 8'h01;
        step();
        checks++; if (out_sel !== 3'd0) begin errors++; $display("FAIL lock_pre got=%0d exp=0", out_sel); end
        in_valid = 8'h03;
        in_last  = 8'hFD;
        for (int k = 0; k < 3; k++) begin
            in_data[1*WIDTH +: WIDTH] = 16'h1001 + 16'(k);
            if (k == 2) in_last = 8'hFF;
            #1;
            checks++; if (in_ready !== 8'h02) begin errors++; $display("FAIL lock_ready_%0d got=%h exp=02", k, in_ready); end
            step();
            checks++;
            if (out_sel !== 3'd1 || out_data !== 16'h1001 + 16'(k) || out_last !== (k == 2)) begin
                errors++;
                $display("FAIL lock_word_%0d got s=%0d d=%h l=%b exp s=1 d=%h l=%b",
                         k, out_sel, out_data, out_last, 16'h1001 + 16'(k), k == 2);
            end
        end
        in_valid = 8'h01;
        step();
        in_valid = 8'h00;
        checks++; if (out_sel !== 3'd0 || out_data !== 16'h0AAA || out_last !== 1'b1) begin
            errors++; $display("FAIL lock_release got s=%0d d=%h l=%b exp s=0 d=0aaa l=1", out_sel, out_data, out_last);
        end
        step();
    endtask
`endif

    initial begin
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b0;
`ifdef MUX8WAY_RR_ARBITER_LOCK_EN
        in_last   = 8'hFF;
`endif
        #2;
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_backpressure();
        test_reset_mid();
`ifdef MUX8WAY_RR_ARBITER_LOCK_EN
        test_lock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
